// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit.
// States, opcodes, ALU/mux select codes and the control word bundle.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_OUT = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_legal(logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/ctrl_decode_salidas.sv
// Combinational state -> control word decode.
// Handshake-gated strobes and the reset mask live here.
module ctrl_decode_salidas
  import mips_ctrl_pkg::*;
(
  input  logic       reset,
  input  logic       ready,
  input  state_e     state,
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  ctrl_t c;

  // Per-state control word; anything not set stays 0
  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.i_or_d    = 1'b0;
        c.alu_src_a = 1'b0;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PCSRC_ALU;
        c.ir_write  = ready;
        c.pc_write  = ready;
      end
      S_DECODE: begin
        c.alu_src_a  = 1'b0;
        c.alu_src_b  = SRCB_BR;
        c.alu_op     = ALUOP_ADD;
        c.illegal_op = !op_legal(opcode);
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_dst    = 1'b0;
        c.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        c.i_or_d     = 1'b1;
        c.mem_write  = 1'b1;
        c.instr_done = ready;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.mem_to_reg = 1'b0;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_B;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_OUT;
        c.instr_done    = 1'b1;
      end
      S_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PCSRC_JMP;
        c.instr_done = 1'b1;
      end
      S_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b0;
        c.mem_to_reg = 1'b0;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
  end

  // Reset silences every strobe, even mid-stall
  assign ctrl = reset ? '0 : c;

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle MIPS-subset control FSM.
// Holds the state register and next-state logic.
module control_multiciclo
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  state_e state_q;
  state_e state_d;
  logic   ready;
  ctrl_t  ctrl;

  assign ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:
        if (ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:
        state_d = (opcode == OP_LW) ? S_MEM_READ
                                    : S_MEM_WRITE;
      S_MEM_READ:
        if (ready) state_d = S_MEM_WB;
      S_MEM_WRITE:
        if (ready) state_d = S_FETCH;
      S_EXEC_R:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  ctrl_decode_salidas u_dec (
    .reset  (reset),
    .ready  (ready),
    .state  (state_q),
    .opcode (opcode),
    .ctrl   (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign instr_done    = ctrl.instr_done;
  assign illegal_op    = ctrl.illegal_op;
  assign state         = reset ? 4'd0 : state_q;

endmodule

// File: doc/control_multiciclo.md
Name: control_multiciclo

Overview:
- Moore/Mealy control FSM that sequences a multicycle MIPS-subset datapath: fetch, decode, execute, memory and writeback over several clocks.
- Replaces the per-instruction combinational control of the single-cycle core.
- Drives all datapath enables and mux selects from the IR opcode and a memory-ready handshake.
- Sits between the instruction register/opcode field and the PC, IR, register-file, ALU and unified-memory controls.

Parameters:
- MEM_WAIT_EN, 1, when 1 memory states wait for mem_ready; when 0 mem_ready is ignored and treated as 1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- opcode  input  6  IR[31:26]
- mem_ready  input  1  memory access completes this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero (branch)
- i_or_d  output  1  memory address: 0=PC, 1=ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  IR load
- mem_to_reg  output  1  write-back source: 0=ALUOut, 1=MDR
- reg_dst  output  1  destination register: 0=rt, 1=rd
- reg_write  output  1  register-file write enable
- alu_src_a  output  1  ALU A: 0=PC, 1=A register
- alu_src_b  output  2  ALU B: 00=B, 01=const 4, 10=sign-extended imm, 11=imm<<2
- alu_op  output  2  00=add, 01=sub, 10=funct-decoded
- pc_source  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
- state  output  4  current state, for debug
- instr_done  output  1  one-cycle pulse on an instruction's final cycle
- illegal_op  output  1  one-cycle pulse when an unsupported opcode is decoded

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11. Codes 12-15 are unused and go to FETCH.
- Reset:
  - Asserting reset loads state=FETCH at the next edge.
  - While reset=1, every output is 0, combinationally masked, including mem_read, pc_write, instr_done and illegal_op.
  - Reset has priority in any state, including a stalled memory state; no write strobe is asserted in that cycle.
- Control outputs are driven in every state not listed as 0.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready: the IR and PC load only in the ready cycle.
  - Goes to DECODE when mem_ready=1; otherwise stays.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target).
  - Next state by opcode: 0x23 (lw) or 0x2B (sw) -> MEM_ADDR, 0x00 (R-type) -> EXEC_R, 0x04 (beq) -> BRANCH, 0x02 (j) -> JUMP, 0x08 (addi) -> ADDI_EXEC.
  - Any other opcode -> FETCH, with illegal_op=1 for this cycle.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_READ if opcode=0x23, else MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1. Goes to MEM_WB on mem_ready, else stays.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Goes to FETCH.
- MEM_WRITE:
  - i_or_d=1; mem_write stays high for the whole stall, and the access completes in the mem_ready cycle.
  - instr_done=mem_ready. Goes to FETCH on mem_ready.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Goes to FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Goes to FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Goes to FETCH.
- opcode is sampled only in DECODE and MEM_ADDR. The datapath holds the IR stable from DECODE until the next FETCH completes.
- Latency with mem_ready=1 throughout:
  - lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each stall cycle in FETCH, MEM_READ or MEM_WRITE adds 1.
- Write enables must never be X after reset.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - the state encodings;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - alu_op codes ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT;
  - alu_src_b and pc_source select codes.
- One sub-module, ctrl_decode_salidas: purely combinational state->output decode, including the mem_ready-gated and reset-masked terms.
- control_multiciclo keeps the state register and next-state logic.

Test Plan:
- Reset for 2 cycles, then lw (opcode 0x23), mem_ready=1 -> state sequence 0,1,2,3,4,0. instr_done high only in state 4, together with reg_write=1 and mem_to_reg=1.
- R-type (0x00) -> sequence 0,1,6,7,0. In state 6: alu_op=10, alu_src_b=00. In state 7: reg_dst=1, reg_write=1. Total 4 cycles.
- beq (0x04) -> in state 8: pc_write_cond=1, pc_source=01, alu_op=01, alu_src_a=1. pc_write=0 throughout state 8. Back in FETCH after 3 cycles.
- mem_ready=0 for 3 cycles in FETCH, then 1 -> state stays 0 for 4 cycles. ir_write and pc_write pulse only in the 4th cycle; mem_read is high all 4 cycles.
- Opcode 0x3F -> 0,1,0 with illegal_op pulsed in the DECODE cycle. No reg_write, mem_write or pc_write_cond is asserted.
- sw (0x2B) stalled in MEM_WRITE with mem_ready=0, then reset=1 -> mem_write=0 during reset. state=0 after the edge; the next fetch starts cleanly once reset drops.
